// File: rtl/counter_reader.sv
// Requester side of the pop-counter readout: sweeps idx 0..NUM_FIFOS-1 with one
// req pulse each, captures the returned counts and publishes their sum.
module counter_reader #(
  parameter int NUM_FIFOS = 5,
  parameter int CNT_W     = 5,
  parameter int TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             IDLE,
  input  logic             start,
  input  logic             valid,
  input  logic [CNT_W-1:0] data_out,
  output logic             req,
  output logic [2:0]       idx,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic [CNT_W-1:0] count3,
  output logic [CNT_W-1:0] count4,
  output logic [7:0]       total,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int         TW   = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST = 3'(NUM_FIFOS - 1);

  typedef enum logic [1:0] {WAIT, REQ, RESP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NUM_FIFOS];
  logic [TW-1:0]    tmo;
  logic [7:0]       sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_FIFOS; i++) sum = sum + 8'(cnt[i]);
  end

  assign count0 = cnt[0];
  assign count1 = cnt[1];
  assign count2 = cnt[2];
  assign count3 = cnt[3];
  assign count4 = cnt[4];

  // A missing response is treated like a received one (minus the capture) so
  // the sweep always completes and err tells the host which run was bad.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= WAIT;
      req   <= 1'b0;
      idx   <= '0;
      total <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      tmo   <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) cnt[i] <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (start && IDLE) begin
            err   <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          req <= 1'b0;
          if (!IDLE) begin
            busy  <= 1'b0;
            state <= WAIT;
          end else begin
            tmo   <= '0;
            state <= RESP;
          end
        end
        RESP: begin
          if (!IDLE) begin
            req   <= 1'b0;
            busy  <= 1'b0;
            state <= WAIT;
          end else if (valid || tmo == TW'(TIMEOUT - 1)) begin
            if (valid) cnt[idx] <= data_out;
            else       err      <= 1'b1;
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              req   <= 1'b1;
              state <= REQ;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          total <= sum;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
